// File: rtl/v_hier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v_hier_pkg
// Description : Shared constants and helpers for the v_hier lane hierarchy.
//               Holds the default lane/word/depth sizing, a clog2 helper and
//               the beats-per-word derivation used by both the forward
//               fan-out path and the return-direction packer.
// Revision    : 1.0 - initial release
// ============================================================================
package v_hier_pkg;

    localparam int V_HIER_LANES = 2;
    localparam int V_HIER_WORD  = 8;
    localparam int V_HIER_DEPTH = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of lane beats that make up one packed word.
    function automatic int beats_per_word(input int word, input int lanes);
        return word / lanes;
    endfunction

    localparam int V_HIER_BEATS = beats_per_word(V_HIER_WORD, V_HIER_LANES);

endpackage : v_hier_pkg
`default_nettype wire

// File: rtl/v_hier_pack_if.sv
`default_nettype none
// ============================================================================
// Module      : v_hier_pack_if
// Description : Beat input and word output handshake bundle of v_hier_pack.
//               in_valid/qvec  : one lane beat per cycle, no back-pressure
//               out_valid/out_ready/out_data : packed word, valid/ready
//               master : lane array + consumer side; slave : the packer
// Revision    : 1.0 - initial release
// ============================================================================
interface v_hier_pack_if
    import v_hier_pkg::*;
#(
    parameter int LANES = V_HIER_LANES,
    parameter int WORD  = V_HIER_WORD
) ();

    logic             in_valid;
    logic [LANES-1:0] qvec;
    logic             out_valid;
    logic             out_ready;
    logic [WORD-1:0]  out_data;

    modport master (
        output in_valid,
        output qvec,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  qvec,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface : v_hier_pack_if
`default_nettype wire

// File: rtl/v_hier_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : v_hier_pack_fifo
// Description : Synchronous word FIFO with exact occupancy count.
//               push/push_data : write request (ignored when full, unless a
//                                pop frees the slot in the same cycle)
//               pop            : read request (ignored when empty)
//               full/empty/level/head : status and head-of-queue word
//               reset_l        : asynchronous active-low reset, clears mem
// Revision    : 1.0 - initial release
// ============================================================================
module v_hier_pack_fifo
    import v_hier_pkg::*;
#(
    parameter  int WORD  = V_HIER_WORD,
    parameter  int DEPTH = V_HIER_DEPTH,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  wire logic            clk,
    input  wire logic            reset_l,
    input  wire logic            push,
    input  wire logic [WORD-1:0] push_data,
    input  wire logic            pop,
    output logic                 full,
    output logic                 empty,
    output logic [LW-1:0]        level,
    output logic [WORD-1:0]      head
);

    logic [WORD-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_pop;
    logic            w_push;

    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign head  = r_mem[r_rd_ptr];

    // A pop on a full FIFO frees the slot, so the same-cycle push fits.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : v_hier_pack_fifo
`default_nettype wire

// File: rtl/v_hier_pack.sv
`default_nettype none
// ============================================================================
// Module      : v_hier_pack
// Description : Gathers per-lane result beats (qvec) into packed words and
//               queues them for a valid/ready consumer. Beat 0 lands in the
//               word MSBs. Words completing while the FIFO is full (and not
//               popping) are dropped and flagged in sticky overflow.
//               clk/reset_l : clock, asynchronous active-low reset
//               bus         : beat input and word output handshake
//               level       : words currently queued
//               overflow    : sticky drop flag, cleared by ovf_clr
// Revision    : 1.0 - initial release
// ============================================================================
module v_hier_pack
    import v_hier_pkg::*;
#(
    parameter  int LANES = V_HIER_LANES,
    parameter  int WORD  = V_HIER_WORD,
    parameter  int DEPTH = V_HIER_DEPTH,
    localparam int BEATS = beats_per_word(WORD, LANES),
    localparam int CW    = clog2(BEATS),
    localparam int LW    = clog2(DEPTH) + 1
) (
    input  wire logic     clk,
    input  wire logic     reset_l,
    v_hier_pack_if.slave  bus,
    input  wire logic     ovf_clr,
    output logic [LW-1:0] level,
    output logic          overflow
);

    // Only the low WORD-LANES bits are kept; the final beat completes the
    // word combinationally, so the full word never needs to be registered.
    logic [WORD-LANES-1:0] r_acc;
    logic [CW-1:0]         r_beat;
    logic                  r_overflow;
    logic [WORD-1:0]       w_word;
    logic                  w_last;
    logic                  w_complete;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;

    assign w_word     = {r_acc, bus.qvec};
    assign w_last     = (r_beat == CW'(BEATS - 1));
    assign w_complete = bus.in_valid & w_last;
    assign w_pop      = ~w_empty & bus.out_ready;
    assign w_drop     = w_complete & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_acc      <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                r_acc  <= w_word[WORD-LANES-1:0];
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            end
            // A new drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    v_hier_pack_fifo #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_l   (reset_l),
        .push      (w_complete),
        .push_data (w_word),
        .pop       (bus.out_ready),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level),
        .head      (bus.out_data)
    );

    assign bus.out_valid = ~w_empty;
    assign overflow      = r_overflow;

endmodule : v_hier_pack
`default_nettype wire
